// File: rtl/mem_pkg.sv
// Shared definitions for the memory initiator: RV32I load/store funct3 codes,
// request source, in-flight tag layout and the default fetch starvation limit.
package mem_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam int unsigned STARVE_LIMIT_DEF = 4;

   typedef enum logic {
      SRC_IF = 1'b0,
      SRC_LS = 1'b1
   } src_e;

   // Response owed in the cycle after an accept.
   typedef struct packed {
      logic valid;
      src_e src;
      logic fault;
   } tag_t;

endpackage

// File: rtl/mem_arbiter.sv
// Grant logic between the fetch and data ports, plus the fetch starvation counter.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   if_req_i        fetch request pending
//   ls_req_i        load/store request pending
//   if_gnt_c_o      fetch granted this cycle (combinational)
//   ls_gnt_c_o      data granted this cycle (combinational)
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req_i,
   input  logic ls_req_i,
   output logic if_gnt_c_o,
   output logic ls_gnt_c_o
);

   localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_q, starve_d;
   logic          fetch_due;

   // Data port has priority until the waiting fetch has lost LIMIT times in a row.
   always_comb begin
      fetch_due  = if_req_i && (starve_q == LIMIT);
      ls_gnt_c_o = rst_n && ls_req_i && !fetch_due;
      if_gnt_c_o = rst_n && if_req_i && !ls_gnt_c_o;
      starve_d   = starve_q;
      if (!if_req_i || if_gnt_c_o) begin
         starve_d = '0;
      end else if (ls_gnt_c_o && (starve_q != LIMIT)) begin
         starve_d = starve_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/mem_initiator.sv
// Shares one single-cycle-latency memory port between an instruction fetch port
// and a load/store port. Misaligned requests are accepted and answered with a
// fault response without touching memory.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   if_req/if_addr -> if_ready         fetch request / accept
//   if_rvalid/if_rdata/if_fault        fetch response (cycle after accept)
//   ls_req/ls_we/ls_funct3/ls_addr/ls_wdata -> ls_ready   data request / accept
//   ls_rvalid/ls_rdata/ls_fault        load or fault response (cycle after accept)
//   write_mem/funct3/write_address/write_data/read_address   memory request
//   read_data                          memory read word, valid the cycle after read_address
module mem_initiator
   import mem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_fault,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [2:0]  ls_funct3,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_ready,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        ls_fault,
   output logic        write_mem,
   output logic [2:0]  funct3,
   output logic [31:0] write_address,
   output logic [31:0] write_data,
   output logic [31:0] read_address,
   input  logic [31:0] read_data
);

   logic if_gnt, ls_gnt;
   logic if_mis, ls_mis;
   tag_t tag_d, tag_q;

   mem_arbiter #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_req_i   (if_req),
      .ls_req_i   (ls_req),
      .if_gnt_c_o (if_gnt),
      .ls_gnt_c_o (ls_gnt)
   );

   assign if_ready = if_gnt;
   assign ls_ready = ls_gnt;

   // Size-dependent alignment check; funct3[1:0] encodes the access size.
   always_comb begin
      if_mis = (if_addr[1:0] != 2'b00);
      unique case (ls_funct3[1:0])
         2'b00:   ls_mis = 1'b0;
         2'b01:   ls_mis = ls_addr[0];
         default: ls_mis = (ls_addr[1:0] != 2'b00);
      endcase
   end

   // Memory request for the granted port and the tag of the response it owes.
   always_comb begin
      write_mem     = 1'b0;
      funct3        = LW;
      write_address = '0;
      write_data    = '0;
      read_address  = '0;
      tag_d         = '{valid: 1'b0, src: SRC_IF, fault: 1'b0};
      if (ls_gnt) begin
         tag_d.src   = SRC_LS;
         tag_d.fault = ls_mis;
         tag_d.valid = ls_mis || !ls_we;
         if (!ls_mis) begin
            funct3 = ls_funct3;
            if (ls_we) begin
               write_mem     = 1'b1;
               write_address = ls_addr;
               write_data    = ls_wdata;
            end else begin
               read_address = ls_addr;
            end
         end
      end else if (if_gnt) begin
         tag_d.valid = 1'b1;
         tag_d.fault = if_mis;
         if (!if_mis) begin
            read_address = if_addr;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q <= '{valid: 1'b0, src: SRC_IF, fault: 1'b0};
      end else begin
         tag_q <= tag_d;
      end
   end

   // Responses: memory word passes straight through unless the request faulted.
   always_comb begin
      if_rvalid = tag_q.valid && (tag_q.src == SRC_IF);
      ls_rvalid = tag_q.valid && (tag_q.src == SRC_LS);
      if_fault  = if_rvalid && tag_q.fault;
      ls_fault  = ls_rvalid && tag_q.fault;
      if_rdata  = (if_rvalid && !tag_q.fault) ? read_data : '0;
      ls_rdata  = (ls_rvalid && !tag_q.fault) ? read_data : '0;
   end

endmodule

// File: tb/tb_mem_initiator.sv
// Randomized bench for mem_initiator with a byte-array memory model driving
// read_data and an independent behavioural model of the expected responses.
module tb_mem_initiator;
   import mem_pkg::*;

   localparam int unsigned LIMIT = 4;
   localparam int unsigned MSZ   = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_ready, if_rvalid, if_fault;
   logic [31:0] if_rdata;
   logic        ls_req = 1'b0;
   logic        ls_we = 1'b0;
   logic [2:0]  ls_funct3 = 3'b010;
   logic [31:0] ls_addr = '0;
   logic [31:0] ls_wdata = '0;
   logic        ls_ready, ls_rvalid, ls_fault;
   logic [31:0] ls_rdata;
   logic        write_mem;
   logic [2:0]  funct3;
   logic [31:0] write_address, write_data, read_address;
   logic [31:0] read_data = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_initiator #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_fault(if_fault),
      .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rvalid(ls_rvalid),
      .ls_rdata(ls_rdata), .ls_fault(ls_fault),
      .write_mem(write_mem), .funct3(funct3), .write_address(write_address),
      .write_data(write_data), .read_address(read_address), .read_data(read_data)
   );

   logic [7:0] bmem [MSZ];   // memory behind the DUT, written by DUT stores
   logic [7:0] mmem [MSZ];   // reference model's view of memory

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
      case (f3)
         3'b000:  return {{24{raw[7]}}, raw[7:0]};
         3'b001:  return {{16{raw[15]}}, raw[15:0]};
         3'b100:  return {24'h0, raw[7:0]};
         3'b101:  return {16'h0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   function automatic int unsigned nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic misaligned(input logic [31:0] a, input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1'b0;
      if (f3[1:0] == 2'b01) return a[0];
      return a[1:0] != 2'b00;
   endfunction

   function automatic logic [31:0] bmem_raw(input logic [31:0] a);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = bmem[a[9:0] + 10'(k)];
      return r;
   endfunction

   function automatic logic [31:0] mmem_raw(input logic [31:0] a);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = mmem[a[9:0] + 10'(k)];
      return r;
   endfunction

   task automatic bmem_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      for (int k = 0; k < int'(nbytes(f3)); k++) bmem[a[9:0] + 10'(k)] = d[8*k +: 8];
   endtask

   task automatic mmem_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      for (int k = 0; k < int'(nbytes(f3)); k++) mmem[a[9:0] + 10'(k)] = d[8*k +: 8];
   endtask

   task automatic put_word(input logic [31:0] a, input logic [31:0] d);
      bmem_store(a, d, 3'b010);
      mmem_store(a, d, 3'b010);
   endtask

   // Memory: request seen at negedge, performed at the following posedge.
   logic        cap_wm = 1'b0;
   logic [2:0]  cap_f3 = 3'b010;
   logic [31:0] cap_wa = '0, cap_wd = '0, cap_ra = '0;

   always @(posedge clk) begin
      if (cap_wm) bmem_store(cap_wa, cap_wd, cap_f3);
      read_data = extend(bmem_raw(cap_ra), cap_f3);
   end

   // Reference model state: one owed response and the fetch's losing streak.
   logic        pend_v = 1'b0, pend_ls = 1'b0, pend_f = 1'b0;
   logic [31:0] pend_d = '0;
   int unsigned starve = 0;
   logic        e_ifg, e_lsg, e_wm, e_ifv, e_iff, e_lsv, e_lsf, e_mis;
   logic [2:0]  e_f3;
   logic [31:0] e_wa, e_wd, e_ra, e_rd;

   always @(negedge clk) begin
      e_ifv = 1'b0; e_iff = 1'b0; e_lsv = 1'b0; e_lsf = 1'b0; e_rd = pend_d;
      e_ifg = 1'b0; e_lsg = 1'b0;
      if (!rst_n) begin
         pend_v = 1'b0;
         starve = 0;
      end else begin
         e_ifv = pend_v && !pend_ls;
         e_lsv = pend_v && pend_ls;
         e_iff = e_ifv && pend_f;
         e_lsf = e_lsv && pend_f;
         e_lsg = ls_req && !(if_req && starve == LIMIT);
         e_ifg = if_req && !e_lsg;
      end
      e_wm = 1'b0; e_f3 = 3'b010; e_wa = '0; e_wd = '0; e_ra = '0;
      if (e_lsg && !misaligned(ls_addr, ls_funct3)) begin
         e_f3 = ls_funct3;
         if (ls_we) begin
            e_wm = 1'b1; e_wa = ls_addr; e_wd = ls_wdata;
         end else begin
            e_ra = ls_addr;
         end
      end else if (e_ifg && if_addr[1:0] == 2'b00) begin
         e_ra = if_addr;
      end
      chk("ready", 128'({if_ready, ls_ready}), 128'({e_ifg, e_lsg}));
      chk("mem_side", 128'({write_mem, funct3, write_address, write_data, read_address}),
          128'({e_wm, e_f3, e_wa, e_wd, e_ra}));
      chk("if_resp", 128'({if_rvalid, if_fault}), 128'({e_ifv, e_iff}));
      if (e_ifv) chk("if_rdata", 128'(if_rdata), 128'(e_rd));
      chk("ls_resp", 128'({ls_rvalid, ls_fault}), 128'({e_lsv, e_lsf}));
      if (e_lsv) chk("ls_rdata", 128'(ls_rdata), 128'(e_rd));
      if (rst_n) begin
         pend_v = 1'b0;
         if (e_lsg) begin
            e_mis   = misaligned(ls_addr, ls_funct3);
            pend_ls = 1'b1;
            pend_f  = e_mis;
            pend_v  = e_mis || !ls_we;
            pend_d  = (e_mis || ls_we) ? 32'h0 : extend(mmem_raw(ls_addr), ls_funct3);
            if (!e_mis && ls_we) mmem_store(ls_addr, ls_wdata, ls_funct3);
         end else if (e_ifg) begin
            e_mis   = (if_addr[1:0] != 2'b00);
            pend_ls = 1'b0;
            pend_f  = e_mis;
            pend_v  = 1'b1;
            pend_d  = e_mis ? 32'h0 : mmem_raw(if_addr);
         end
         if (!if_req || e_ifg) starve = 0;
         else if (e_lsg && starve < LIMIT) starve++;
      end
      cap_wm = write_mem; cap_f3 = funct3; cap_wa = write_address;
      cap_wd = write_data; cap_ra = read_address;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
   endtask

   task automatic drive_ls(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d);
      ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = a; ls_wdata = d;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   logic [5:0]  g_ls, g_if;
   int          n_ifv;
   logic [7:0]  b;
   logic [2:0]  rf3;

   initial begin
      for (int i = 0; i < int'(MSZ); i++) begin
         b = 8'($urandom);
         bmem[i] = b;
         mmem[i] = b;
      end
      put_word(32'h100, 32'hDEADBEEF);
      put_word(32'h0, 32'h00000013);
      put_word(32'h4, 32'h00100093);
      put_word(32'h8, 32'h00200113);

      repeat (2) @(negedge clk);
      chk("reset_outputs", 128'({if_ready, ls_ready, write_mem, funct3, if_rvalid, ls_rvalid}),
          128'({1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0}));
      tick();
      rst_n = 1'b1;

      // Aligned word load.
      tick(); drive_ls(1'b0, LW, 32'h100, 32'h0);
      @(negedge clk);
      chk("lw_ready", 128'(ls_ready), 128'(1));
      chk("lw_read_address", 128'(read_address), 128'(32'h100));
      tick(); idle();
      @(negedge clk);
      chk("lw_rvalid", 128'(ls_rvalid), 128'(1));
      chk("lw_rdata", 128'(ls_rdata), 128'(32'hDEADBEEF));

      // Both ports held: fetch wins once after LIMIT data grants.
      tick(); if_req = 1'b1; if_addr = 32'h10; drive_ls(1'b0, LW, 32'h104, 32'h0);
      n_ifv = 0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         @(negedge clk);
         g_ls[i] = ls_ready;
         g_if[i] = if_ready;
         n_ifv += int'(if_rvalid);
      end
      tick(); idle();
      @(negedge clk);
      n_ifv += int'(if_rvalid);
      chk("starve_ls_grants", 128'(g_ls), 128'(6'b101111));
      chk("starve_if_grants", 128'(g_if), 128'(6'b010000));
      chk("starve_if_rvalid_once", 128'(n_ifv), 128'(1));

      // Byte store then LBU of the same byte.
      tick(); drive_ls(1'b1, SB, 32'h203, 32'h000000AB);
      @(negedge clk);
      chk("sb_write", 128'({write_mem, write_address, write_data, funct3}),
          128'({1'b1, 32'h203, 32'h000000AB, 3'b000}));
      tick(); idle();
      @(negedge clk);
      chk("sb_one_cycle_no_resp", 128'({write_mem, ls_rvalid}), 128'(0));
      tick(); drive_ls(1'b0, LBU, 32'h203, 32'h0);
      @(negedge clk);
      tick(); idle();
      @(negedge clk);
      chk("lbu_rdata", 128'({ls_rvalid, ls_rdata}), 128'({1'b1, 32'h000000AB}));

      // Misaligned word load faults without a memory access.
      tick(); drive_ls(1'b0, LW, 32'h102, 32'h0);
      @(negedge clk);
      chk("mis_no_access", 128'({ls_ready, write_mem, read_address}), 128'({1'b1, 1'b0, 32'h0}));
      tick(); idle();
      @(negedge clk);
      chk("mis_fault_resp", 128'({ls_rvalid, ls_fault, ls_rdata}), 128'({1'b1, 1'b1, 32'h0}));

      // Back-to-back fetches.
      tick(); if_req = 1'b1; if_addr = 32'h0;
      @(negedge clk);
      chk("fetch0_ready", 128'(if_ready), 128'(1));
      tick(); if_addr = 32'h4;
      @(negedge clk);
      chk("fetch0_data", 128'({if_rvalid, if_rdata}), 128'({1'b1, 32'h00000013}));
      tick(); if_addr = 32'h8;
      @(negedge clk);
      chk("fetch1_data", 128'({if_rvalid, if_rdata}), 128'({1'b1, 32'h00100093}));
      tick(); idle();
      @(negedge clk);
      chk("fetch2_data", 128'({if_rvalid, if_rdata}), 128'({1'b1, 32'h00200113}));

      // Reset with a load in flight.
      tick(); drive_ls(1'b0, LW, 32'h100, 32'h0);
      @(negedge clk);
      chk("rst_load_accept", 128'(ls_ready), 128'(1));
      tick(); idle();
      rst_n = 1'b0;
      #1;
      chk("async_reset", 128'({ls_rvalid, ls_ready, if_ready, write_mem, funct3}),
          128'({1'b0, 1'b0, 1'b0, 1'b0, 3'b010}));
      @(negedge clk);
      tick(); rst_n = 1'b1; drive_ls(1'b0, LW, 32'h104, 32'h0);
      @(negedge clk);
      chk("post_reset_discard", 128'(ls_rvalid), 128'(0));
      chk("post_reset_first_accept", 128'(ls_ready), 128'(1));
      tick(); idle();
      @(negedge clk);

      // Random traffic with occasional reset pulses.
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst_n   = ($urandom_range(0, 299) != 0);
         if_req  = ($urandom_range(0, 9) < 7);
         if_addr = $urandom_range(0, MSZ - 1);
         if ($urandom_range(0, 3) != 0) if_addr[1:0] = 2'b00;
         ls_req  = ($urandom_range(0, 9) < 7);
         ls_we   = 1'($urandom_range(0, 1));
         case ($urandom_range(0, ls_we ? 2 : 4))
            0:       rf3 = ls_we ? SB : LB;
            1:       rf3 = ls_we ? SH : LH;
            2:       rf3 = ls_we ? SW : LW;
            3:       rf3 = LBU;
            default: rf3 = LHU;
         endcase
         ls_funct3 = rf3;
         ls_addr   = $urandom_range(0, MSZ - 1);
         if ($urandom_range(0, 3) != 0) begin
            if (rf3[1:0] == 2'b10) ls_addr[1:0] = 2'b00;
            if (rf3[1:0] == 2'b01) ls_addr[0] = 1'b0;
         end
         ls_wdata = $urandom;
      end
      tick(); idle(); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
